// File: rtl/riscv_fetch_pkg.sv
// -----------------------------------------------------------------------------
// riscv_fetch_pkg
// Shared definitions for the fetch front end of the single-cycle RISC-V core.
//   PC_W_DEFAULT      : default PC / byte-address width
//   RESET_PC_DEFAULT  : default PC loaded on reset (must be word-aligned)
//   HALT_INSN_DEFAULT : encoding of jal x0,0 (self-loop), which halts fetch
//   fetch_state_e     : fetch sequencer states, 2-bit encoding
//   is_misaligned()   : true when a byte address is not word-aligned
// -----------------------------------------------------------------------------
package riscv_fetch_pkg;

  localparam int unsigned PC_W_DEFAULT      = 8;
  localparam logic [7:0]  RESET_PC_DEFAULT  = 8'h00;
  localparam logic [31:0] HALT_INSN_DEFAULT = 32'h0000_006F;

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10,
    ST_TRAP = 2'b11
  } fetch_state_e;

  // Word alignment test on the two low address bits.
  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return (addr_lo != 2'b00);
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// -----------------------------------------------------------------------------
// next_pc_sel
// Combinational next-state / next-PC selection for fetch_unit. In RUN the
// priority is: misaligned redirect (trap) > aligned redirect (flush) >
// capture-and-advance > stall (hold). HALT only drains the held instruction,
// TRAP and BOOT never capture.
// Ports:
//   state           in  current sequencer state
//   pc              in  current fetch PC
//   if_valid        in  holding register contains a live instruction
//   id_ready        in  decode consumes the held instruction this cycle
//   redirect_valid  in  branch/jump resolved this cycle
//   redirect_target in  redirect destination
//   instr_in        in  word fetched from pc this cycle
//   next_state      out state for the next cycle
//   next_pc         out PC for the next cycle
//   load            out capture instr_in/pc into the holding register
//   flush           out drop the held instruction (aligned redirect)
//   trap_set        out misaligned redirect seen, latch trap and trap_pc
//   drain           out held HALT instruction consumed, clear if_valid
// -----------------------------------------------------------------------------
module next_pc_sel
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned    PC_W      = PC_W_DEFAULT,
  parameter logic [31:0]    HALT_INSN = HALT_INSN_DEFAULT
) (
  input  fetch_state_e       state,
  input  logic [PC_W-1:0]    pc,
  input  logic               if_valid,
  input  logic               id_ready,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_target,
  input  logic [31:0]        instr_in,
  output fetch_state_e       next_state,
  output logic [PC_W-1:0]    next_pc,
  output logic               load,
  output logic               flush,
  output logic               trap_set,
  output logic               drain
);

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(3'd4);

  // Priority selection of the next fetch action.
  always_comb begin
    next_state = state;
    next_pc    = pc;
    load       = 1'b0;
    flush      = 1'b0;
    trap_set   = 1'b0;
    drain      = 1'b0;
    case (state)
      ST_BOOT: begin
        next_state = ST_RUN;
      end
      ST_RUN: begin
        if (redirect_valid && is_misaligned(redirect_target[1:0])) begin
          // pc is left untouched so it still points at the last good fetch
          trap_set   = 1'b1;
          next_state = ST_TRAP;
        end else if (redirect_valid) begin
          // flush wins over id_ready; the outgoing word counts as consumed
          flush   = 1'b1;
          next_pc = redirect_target;
        end else if (!if_valid || id_ready) begin
          load = 1'b1;
          if (instr_in == HALT_INSN) begin
            next_state = ST_HALT;
          end else begin
            next_pc = pc + PC_STEP;
          end
        end else begin
          // stall: decode is holding, everything stays put
          next_pc = pc;
        end
      end
      ST_HALT: begin
        if (if_valid && id_ready) begin
          drain = 1'b1;
        end else begin
          drain = 1'b0;
        end
      end
      ST_TRAP: begin
        next_state = ST_TRAP;
      end
      default: begin
        next_state = ST_BOOT;
      end
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Front end of the single-cycle RISC-V core. Owns the PC, addresses the
// combinational instruction memory, and registers the returned word into a
// fetch/decode holding register with a valid/ready handshake. Accepts
// redirects, traps on misaligned targets, and halts on jal x0,0.
// Optional build macro FETCH_PERF_EN adds fetch_cnt / stall_cnt counters.
// Ports:
//   clk             in  system clock, rising edge
//   rst             in  synchronous active-high reset
//   pc              out fetch address to instruction memory
//   instr_in        in  word at pc (combinational, same cycle)
//   if_instr        out registered instruction to decode
//   if_pc           out PC of if_instr
//   if_valid        out if_instr/if_pc hold a live instruction
//   id_ready        in  decode consumes if_instr when if_valid=1
//   redirect_valid  in  branch taken / jal / jalr resolved this cycle
//   redirect_target in  new PC (bit 0 already cleared for jalr)
//   halted          out fetch stopped on the halt instruction
//   trap            out misaligned redirect target seen
//   trap_pc         out offending target
//   fetch_cnt       out (FETCH_PERF_EN) number of captures, wraps
//   stall_cnt       out (FETCH_PERF_EN) RUN cycles stalled by decode, wraps
// -----------------------------------------------------------------------------
module fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned      PC_W      = PC_W_DEFAULT,
  parameter logic [PC_W-1:0]  RESET_PC  = PC_W'(RESET_PC_DEFAULT),
  parameter logic [31:0]      HALT_INSN = HALT_INSN_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  output logic [PC_W-1:0]  pc,
  input  logic [31:0]      instr_in,
  output logic [31:0]      if_instr,
  output logic [PC_W-1:0]  if_pc,
  output logic             if_valid,
  input  logic             id_ready,
  input  logic             redirect_valid,
  input  logic [PC_W-1:0]  redirect_target,
  output logic             halted,
  output logic             trap,
  output logic [PC_W-1:0]  trap_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]      fetch_cnt,
  output logic [15:0]      stall_cnt
`endif
);

  fetch_state_e      state_r;
  fetch_state_e      next_state_s;
  logic [PC_W-1:0]   next_pc_s;
  logic              load_s;
  logic              flush_s;
  logic              trap_set_s;
  logic              drain_s;

  next_pc_sel #(
    .PC_W      (PC_W),
    .HALT_INSN (HALT_INSN)
  ) u_next_pc_sel (
    .state           (state_r),
    .pc              (pc),
    .if_valid        (if_valid),
    .id_ready        (id_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .instr_in        (instr_in),
    .next_state      (next_state_s),
    .next_pc         (next_pc_s),
    .load            (load_s),
    .flush           (flush_s),
    .trap_set        (trap_set_s),
    .drain           (drain_s)
  );

  // Sequencer state and program counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_BOOT;
      pc      <= RESET_PC;
    end else begin
      state_r <= next_state_s;
      pc      <= next_pc_s;
    end
  end

  // Fetch/decode holding register with valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_instr <= 32'h0000_0000;
      if_pc    <= {PC_W{1'b0}};
      if_valid <= 1'b0;
    end else if (load_s) begin
      if_instr <= instr_in;
      if_pc    <= pc;
      if_valid <= 1'b1;
    end else if (flush_s || trap_set_s || drain_s) begin
      if_valid <= 1'b0;
    end else begin
      if_valid <= if_valid;
    end
  end

  // Sticky status outputs: halted follows entry into HALT on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      halted  <= 1'b0;
      trap    <= 1'b0;
      trap_pc <= {PC_W{1'b0}};
    end else begin
      halted <= (next_state_s == ST_HALT);
      if (trap_set_s) begin
        trap    <= 1'b1;
        trap_pc <= redirect_target;
      end else begin
        trap    <= trap;
        trap_pc <= trap_pc;
      end
    end
  end

`ifdef FETCH_PERF_EN
  // Performance counters: captures and decode-induced stalls in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= 16'h0000;
      stall_cnt <= 16'h0000;
    end else begin
      if (load_s) begin
        fetch_cnt <= fetch_cnt + 16'h0001;
      end else begin
        fetch_cnt <= fetch_cnt;
      end
      if ((state_r == ST_RUN) && if_valid && !id_ready) begin
        stall_cnt <= stall_cnt + 16'h0001;
      end else begin
        stall_cnt <= stall_cnt;
      end
    end
  end
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run,
// all compared against a behavioural model of the fetch rules.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
  import riscv_fetch_pkg::*;

  localparam logic [31:0] HALT_W = 32'h0000_006F;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pc;
  logic [31:0] instr_in;
  logic [31:0] if_instr;
  logic [7:0]  if_pc;
  logic        if_valid;
  logic        id_ready;
  logic        redirect_valid;
  logic [7:0]  redirect_target;
  logic        halted;
  logic        trap;
  logic [7:0]  trap_pc;
`ifdef FETCH_PERF_EN
  logic [15:0] fetch_cnt;
  logic [15:0] stall_cnt;
`endif

  logic [31:0] mem [0:63];

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state
  int          m_pc, m_ipc, m_tpc, m_fcnt, m_scnt;
  logic [31:0] m_instr;
  bit          m_valid, m_halted, m_trapped, m_boot;

  always #5 clk = ~clk;

  assign instr_in = mem[pc[7:2]];

  fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .pc              (pc),
    .instr_in        (instr_in),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .if_valid        (if_valid),
    .id_ready        (id_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halted          (halted),
    .trap            (trap),
    .trap_pc         (trap_pc)
`ifdef FETCH_PERF_EN
    ,
    .fetch_cnt       (fetch_cnt),
    .stall_cnt       (stall_cnt)
`endif
  );

  // Apply the fetch rules for one rising edge, using the inputs now driven.
  task automatic model_edge();
    logic [31:0] word;
    if (rst) begin
      m_pc = 0; m_ipc = 0; m_tpc = 0; m_instr = 32'h0;
      m_valid = 0; m_halted = 0; m_trapped = 0; m_boot = 1;
      m_fcnt = 0; m_scnt = 0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (m_trapped) begin
      m_valid = 0;
    end else if (m_halted) begin
      if (m_valid && id_ready) m_valid = 0;
    end else begin
      if (m_valid && !id_ready) m_scnt = (m_scnt + 1) % 65536;
      if (redirect_valid && (redirect_target % 4) != 0) begin
        m_trapped = 1; m_tpc = redirect_target; m_valid = 0;
      end else if (redirect_valid) begin
        m_pc = redirect_target; m_valid = 0;
      end else if (!m_valid || id_ready) begin
        word = mem[m_pc / 4];
        m_instr = word; m_ipc = m_pc; m_valid = 1;
        m_fcnt = (m_fcnt + 1) % 65536;
        if (word == HALT_W) m_halted = 1;
        else m_pc = (m_pc + 4) % 256;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [58:0] obs_vec();
    return {pc, if_valid, if_pc, if_instr, halted, trap, trap_pc};
  endfunction

  function automatic logic [58:0] exp_vec();
    return {8'(m_pc), m_valid, 8'(m_ipc), m_instr, m_halted, m_trapped, 8'(m_tpc)};
  endfunction

  task automatic fill_mem();
    logic [31:0] w;
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      if (w == HALT_W) w = w ^ 32'h1;
      mem[i] = w;
    end
  endtask

  task automatic test_reset();
    rst = 1; id_ready = 0; redirect_valid = 0; redirect_target = 8'h00;
    step();
    step();
    n_checks++;
    if (obs_vec() !== 59'h0) begin
      n_fail++; $display("FAIL reset_state: got %h expected %h", obs_vec(), 59'h0);
    end
`ifdef FETCH_PERF_EN
    n_checks++;
    if ({fetch_cnt, stall_cnt} !== 32'h0) begin
      n_fail++; $display("FAIL reset_counters: got %h expected 0", {fetch_cnt, stall_cnt});
    end
`endif
  endtask

  task automatic test_sequential();
    logic [7:0] exp_pcs [3];
    exp_pcs[0] = 8'h00; exp_pcs[1] = 8'h04; exp_pcs[2] = 8'h08;
    mem[0] = 32'h00500093; mem[1] = 32'h00A00113;
    rst = 0; id_ready = 1;
    step();  // BOOT cycle, no capture
    n_checks++;
    if (if_valid !== 1'b0 || pc !== 8'h00) begin
      n_fail++; $display("FAIL boot_no_capture: got valid=%b pc=%h expected valid=0 pc=00", if_valid, pc);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (if_valid !== 1'b1 || if_pc !== exp_pcs[i]) begin
        n_fail++; $display("FAIL seq_if_pc[%0d]: got valid=%b if_pc=%h expected 1 %h", i, if_valid, if_pc, exp_pcs[i]);
      end
      if (i == 0) begin
        n_checks++;
        if (if_instr !== 32'h00500093) begin
          n_fail++; $display("FAIL seq_instr0: got %h expected 00500093", if_instr);
        end
      end else if (i == 1) begin
        n_checks++;
        if (if_instr !== 32'h00A00113) begin
          n_fail++; $display("FAIL seq_instr1: got %h expected 00A00113", if_instr);
        end
      end
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL seq_model[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0]  hold_pc, hold_ipc;
    logic [31:0] hold_instr;
    hold_pc = pc; hold_ipc = if_pc; hold_instr = if_instr;
    id_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (pc !== hold_pc || if_pc !== hold_ipc || if_instr !== hold_instr || if_valid !== 1'b1) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got pc=%h if_pc=%h instr=%h v=%b expected %h %h %h 1",
                           i, pc, if_pc, if_instr, if_valid, hold_pc, hold_ipc, hold_instr);
      end
    end
`ifdef FETCH_PERF_EN
    n_checks++;
    if (stall_cnt !== 16'd3) begin
      n_fail++; $display("FAIL stall_cnt: got %0d expected 3", stall_cnt);
    end
`endif
  endtask

  task automatic test_redirect();
    id_ready = 0; redirect_valid = 1; redirect_target = 8'h58;
    step();
    redirect_valid = 0;
    n_checks++;
    if (if_valid !== 1'b0 || pc !== 8'h58) begin
      n_fail++; $display("FAIL redirect_flush: got valid=%b pc=%h expected 0 58", if_valid, pc);
    end
    step();
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 8'h58 || if_instr !== mem[22]) begin
      n_fail++; $display("FAIL redirect_capture: got valid=%b if_pc=%h instr=%h expected 1 58 %h", if_valid, if_pc, if_instr, mem[22]);
    end
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL redirect_model: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_trap();
    logic [7:0] pc_at_trap;
    pc_at_trap = pc;
    redirect_valid = 1; redirect_target = 8'h5A; id_ready = 1;
    step();
    n_checks++;
    if (trap !== 1'b1 || trap_pc !== 8'h5A || if_valid !== 1'b0 || pc !== pc_at_trap) begin
      n_fail++; $display("FAIL trap_entry: got trap=%b tpc=%h v=%b pc=%h expected 1 5a 0 %h", trap, trap_pc, if_valid, pc, pc_at_trap);
    end
    for (int i = 0; i < 8; i++) begin
      redirect_valid = 1'($urandom); redirect_target = 8'($urandom); id_ready = 1'($urandom);
      step();
      n_checks++;
      if (trap !== 1'b1 || trap_pc !== 8'h5A || if_valid !== 1'b0 || pc !== pc_at_trap) begin
        n_fail++; $display("FAIL trap_sticky[%0d]: got trap=%b tpc=%h v=%b pc=%h", i, trap, trap_pc, if_valid, pc);
      end
    end
    redirect_valid = 0;
  endtask

  task automatic test_halt();
    mem[34] = HALT_W;
    rst = 1; step(); rst = 0; id_ready = 0;
    step();  // BOOT
    redirect_valid = 1; redirect_target = 8'h88;
    step();
    redirect_valid = 0;
    step();
    n_checks++;
    if (if_pc !== 8'h88 || if_instr !== HALT_W || halted !== 1'b1 || pc !== 8'h88 || if_valid !== 1'b1) begin
      n_fail++; $display("FAIL halt_capture: got if_pc=%h instr=%h halted=%b pc=%h v=%b", if_pc, if_instr, halted, pc, if_valid);
    end
    redirect_valid = 1; redirect_target = 8'h10;
    step();
    n_checks++;
    if (if_valid !== 1'b1 || pc !== 8'h88) begin
      n_fail++; $display("FAIL halt_ignore_redirect: got v=%b pc=%h expected 1 88", if_valid, pc);
    end
    redirect_valid = 0; id_ready = 1;
    step();
    n_checks++;
    if (if_valid !== 1'b0 || halted !== 1'b1 || pc !== 8'h88) begin
      n_fail++; $display("FAIL halt_drain: got v=%b halted=%b pc=%h expected 0 1 88", if_valid, halted, pc);
    end
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL halt_model: got %h expected %h", obs_vec(), exp_vec());
    end
    mem[34] = 32'h00000013;
  endtask

  task automatic test_wrap();
    logic [7:0] exp_pcs [3];
    exp_pcs[0] = 8'hF8; exp_pcs[1] = 8'hFC; exp_pcs[2] = 8'h00;
    rst = 1; step(); rst = 0; id_ready = 1;
    step();  // BOOT
    redirect_valid = 1; redirect_target = 8'hF8;
    step();
    redirect_valid = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (if_pc !== exp_pcs[i] || if_valid !== 1'b1) begin
        n_fail++; $display("FAIL wrap_if_pc[%0d]: got %h v=%b expected %h 1", i, if_pc, if_valid, exp_pcs[i]);
      end
    end
    rst = 1;
    step();
    rst = 0;
    n_checks++;
    if (obs_vec() !== 59'h0) begin
      n_fail++; $display("FAIL midstream_reset: got %h expected 0", obs_vec());
    end
  endtask

  task automatic test_random();
    int stuck = 0;
    fill_mem();
    mem[$urandom_range(8, 63)] = HALT_W;
    mem[$urandom_range(8, 63)] = HALT_W;
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 199) == 0) || (stuck > 12);
      id_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_target = 8'($urandom) & 8'hFC;
      if ($urandom_range(0, 4) == 0) redirect_target = redirect_target | 8'($urandom_range(1, 3));
      step();
      stuck = (m_halted || m_trapped) ? stuck + 1 : 0;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random_model[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
`ifdef FETCH_PERF_EN
      n_checks++;
      if (fetch_cnt !== 16'(m_fcnt) || stall_cnt !== 16'(m_scnt)) begin
        n_fail++; $display("FAIL random_perf[%0d]: got %0d %0d expected %0d %0d", i, fetch_cnt, stall_cnt, m_fcnt, m_scnt);
      end
`endif
    end
  endtask

  initial begin
    rst = 1; id_ready = 0; redirect_valid = 0; redirect_target = 8'h00;
    fill_mem();
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_trap();
    test_halt();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
